// File: rtl/inverter_bank_tester_if.sv
// rtl/inverter_bank_tester_if.sv - control, status and inverter-bank signals of the bank tester
interface inverter_bank_tester_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] inv_x;
   logic [WIDTH-1:0] inv_zn;
   logic             busy;
   logic             done;
   logic             pass;
   logic [7:0]       err_count;
   logic [WIDTH-1:0] first_fail;

   modport master (
      output start, abort, inv_zn,
      input  inv_x, busy, done, pass, err_count, first_fail
   );

   modport slave (
      input  start, abort, inv_zn,
      output inv_x, busy, done, pass, err_count, first_fail
   );
endinterface

// File: rtl/inverter_bank_tester.sv
// rtl/inverter_bank_tester.sv - sweeps all patterns through an inverter bank and checks ZN == ~X
module inverter_bank_tester #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input logic                    clk,
   input logic                    rst,
   inverter_bank_tester_if.slave  bus
);
   typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

   localparam int               CW          = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [WIDTH:0]   LAST_IDX    = {1'b0, {WIDTH{1'b1}}};

   state_t           state_q, state_d;
   logic [WIDTH:0]   idx_q, idx_d;
   logic [WIDTH-1:0] inv_x_q, inv_x_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [7:0]       err_count_q, err_count_d;
   logic [WIDTH-1:0] first_fail_q, first_fail_d;
   logic             pass_q, pass_d;

   logic             mismatch;
   logic [7:0]       err_inc;
   logic [7:0]       err_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         inv_x_q      <= '0;
         cnt_q        <= '0;
         err_count_q  <= '0;
         first_fail_q <= '0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         inv_x_q      <= inv_x_d;
         cnt_q        <= cnt_d;
         err_count_q  <= err_count_d;
         first_fail_q <= first_fail_d;
         pass_q       <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: if (bus.start) state_d = S_DRIVE;
            S_DRIVE:        state_d = S_SETTLE;
            S_SETTLE:       if (cnt_q == '0) state_d = S_CHECK;
            S_CHECK:        state_d = (idx_q == LAST_IDX) ? S_DONE : S_DRIVE;
            default:        state_d = S_IDLE;
         endcase
      end
   end

   assign mismatch = (bus.inv_zn != ~inv_x_q);
   assign err_inc  = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
   assign err_next = mismatch ? err_inc : err_count_q;

   // Abort leaves err_count/first_fail at their partial values; only inv_x is parked.
   always_comb begin
      idx_d        = idx_q;
      inv_x_d      = inv_x_q;
      cnt_d        = cnt_q;
      err_count_d  = err_count_q;
      first_fail_d = first_fail_q;
      pass_d       = pass_q;
      if (bus.abort) begin
         inv_x_d = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (state_q == S_IDLE) inv_x_d = '0;
               if (bus.start) begin
                  idx_d        = '0;
                  err_count_d  = '0;
                  first_fail_d = '0;
                  pass_d       = 1'b0;
               end
            end
            S_DRIVE: begin
               inv_x_d = idx_q[WIDTH-1:0];
               cnt_d   = SETTLE_LOAD;
            end
            S_SETTLE: begin
               if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            S_CHECK: begin
               err_count_d = err_next;
               if (mismatch && (err_count_q == 8'd0)) first_fail_d = idx_q[WIDTH-1:0];
               if (idx_q == LAST_IDX) pass_d = (err_next == 8'd0);
               else                   idx_d  = idx_q + {{WIDTH{1'b0}}, 1'b1};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.busy       = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
      bus.done       = (state_q == S_DONE);
      bus.pass       = pass_q;
      bus.inv_x      = inv_x_q;
      bus.err_count  = err_count_q;
      bus.first_fail = first_fail_q;
   end
endmodule

// File: tb/tb_inverter_bank_tester.sv
// tb/tb_inverter_bank_tester.sv - directed checks of the inverter bank tester
module tb_inverter_bank_tester;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   mode = 0;

   logic [3:0] d1, d2, d3, e1, e2, e3;

   inverter_bank_tester_if #(.WIDTH(4)) bus ();
   inverter_bank_tester_if #(.WIDTH(4)) bus3 ();

   inverter_bank_tester #(.WIDTH(4), .SETTLE_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   inverter_bank_tester #(.WIDTH(4), .SETTLE_CYCLES(3)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3.slave)
   );

   always #5 clk = ~clk;

   // Inverter models: ideal, ZN[2] stuck-at-0, and ideal with a 3-cycle output delay.
   always @(posedge clk) begin
      d1 <= ~bus.inv_x;  d2 <= d1; d3 <= d2;
      e1 <= ~bus3.inv_x; e2 <= e1; e3 <= e2;
   end
   assign bus.inv_zn  = (mode == 0) ? ~bus.inv_x :
                        (mode == 1) ? (~bus.inv_x & 4'b1011) : d3;
   assign bus3.inv_zn = e3;

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic pulse_abort();
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (bus.inv_x !== 4'd0) begin errors++; $display("FAIL reset_inv_x got %0d exp 0", bus.inv_x); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", bus.done); end
      checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %0b exp 0", bus.pass); end
      checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", bus.err_count); end
      checks++; if (bus.first_fail !== 4'd0) begin errors++; $display("FAIL reset_ff got %0d exp 0", bus.first_fail); end
   endtask

   task automatic test_ideal_run();
      mode = 0;
      pulse_start();
      repeat (63) @(negedge clk);
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL ideal_busy63 got busy=%0b done=%0b exp busy=1 done=0", bus.busy, bus.done); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL ideal_done64 got done=%0b busy=%0b exp done=1 busy=0", bus.done, bus.busy); end
      checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL ideal_pass got %0b exp 1", bus.pass); end
      checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL ideal_err got %0d exp 0", bus.err_count); end
      checks++; if (bus.first_fail !== 4'd0) begin errors++; $display("FAIL ideal_ff got %0d exp 0", bus.first_fail); end
      checks++; if (bus.inv_x !== 4'd15) begin errors++; $display("FAIL ideal_inv_x_held got %0d exp 15", bus.inv_x); end
   endtask

   task automatic test_stuck();
      mode = 1;
      pulse_start();
      repeat (64) @(negedge clk);
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stuck_done got %0b exp 1", bus.done); end
      checks++; if (bus.err_count !== 8'd8) begin errors++; $display("FAIL stuck_err got %0d exp 8", bus.err_count); end
      checks++; if (bus.first_fail !== 4'd0) begin errors++; $display("FAIL stuck_ff got %0d exp 0", bus.first_fail); end
      checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL stuck_pass got %0b exp 0", bus.pass); end
   endtask

   task automatic test_settle();
      mode = 2;
      pulse_abort();
      repeat (5) @(negedge clk);
      pulse_start();
      repeat (64) @(negedge clk);
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL slow2_done got %0b exp 1", bus.done); end
      checks++; if (bus.err_count !== 8'd15) begin errors++; $display("FAIL slow2_err got %0d exp 15", bus.err_count); end
      checks++; if (bus.first_fail !== 4'd1) begin errors++; $display("FAIL slow2_ff got %0d exp 1", bus.first_fail); end
      checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL slow2_pass got %0b exp 0", bus.pass); end
      bus3.start = 1'b1;
      @(negedge clk);
      bus3.start = 1'b0;
      repeat (79) @(negedge clk);
      checks++; if (bus3.done !== 1'b0 || bus3.busy !== 1'b1) begin errors++; $display("FAIL slow3_busy79 got done=%0b busy=%0b exp done=0 busy=1", bus3.done, bus3.busy); end
      @(negedge clk);
      checks++; if (bus3.done !== 1'b1) begin errors++; $display("FAIL slow3_done80 got %0b exp 1", bus3.done); end
      checks++; if (bus3.pass !== 1'b1 || bus3.err_count !== 8'd0) begin errors++; $display("FAIL slow3_pass got pass=%0b err=%0d exp pass=1 err=0", bus3.pass, bus3.err_count); end
   endtask

   task automatic test_abort();
      mode = 1;
      pulse_start();
      repeat (19) @(negedge clk);
      bus.start = 1'b1;
      pulse_abort();
      bus.start = 1'b0;
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%0b done=%0b exp 0 0", bus.busy, bus.done); end
      checks++; if (bus.inv_x !== 4'd0) begin errors++; $display("FAIL abort_inv_x got %0d exp 0", bus.inv_x); end
      checks++; if (bus.err_count !== 8'd4) begin errors++; $display("FAIL abort_partial_err got %0d exp 4", bus.err_count); end
      repeat (3) @(negedge clk);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_idle_hold got done=%0b busy=%0b exp 0 0", bus.done, bus.busy); end
      mode = 0;
      pulse_start();
      repeat (64) @(negedge clk);
      checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.err_count !== 8'd0) begin errors++; $display("FAIL abort_rerun got done=%0b pass=%0b err=%0d exp 1 1 0", bus.done, bus.pass, bus.err_count); end
   endtask

   task automatic test_rst_midrun();
      mode = 1;
      pulse_start();
      repeat (30) @(negedge clk);
      checks++; if (bus.err_count !== 8'd4 || bus.busy !== 1'b1) begin errors++; $display("FAIL rst_pre got err=%0d busy=%0b exp 4 1", bus.err_count, bus.busy); end
      rst = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.inv_x !== 4'd0) begin errors++; $display("FAIL rst_async got busy=%0b done=%0b inv_x=%0d exp 0 0 0", bus.busy, bus.done, bus.inv_x); end
      checks++; if (bus.err_count !== 8'd0 || bus.first_fail !== 4'd0 || bus.pass !== 1'b0) begin errors++; $display("FAIL rst_results got err=%0d ff=%0d pass=%0b exp 0 0 0", bus.err_count, bus.first_fail, bus.pass); end
      @(negedge clk);
      rst = 1'b0;
      mode = 0;
      @(negedge clk);
      pulse_start();
      repeat (64) @(negedge clk);
      checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b1) begin errors++; $display("FAIL rst_rerun got done=%0b pass=%0b exp 1 1", bus.done, bus.pass); end
   endtask

   task automatic test_start_held();
      mode = 0;
      bus.start = 1'b1;
      @(negedge clk);
      repeat (63) @(negedge clk);
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL held_busy63 got busy=%0b done=%0b exp 1 0", bus.busy, bus.done); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b1) begin errors++; $display("FAIL held_done64 got done=%0b pass=%0b exp 1 1", bus.done, bus.pass); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL held_restart got done=%0b busy=%0b exp 0 1", bus.done, bus.busy); end
      bus.start = 1'b0;
      pulse_abort();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL held_abort got busy=%0b exp 0", bus.busy); end
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      bus3.start = 1'b0;
      bus3.abort = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      repeat (5) @(negedge clk);
      test_ideal_run();
      test_stuck();
      test_settle();
      test_abort();
      test_rst_midrun();
      test_start_held();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
